// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver: one shared hex decoder, a one-hot anode
// scanner, and a pending/display double buffer that only swaps at frame boundaries.
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           pc_q, pc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic       slot_end, wrap, upper_nz, blanked;
  logic [3:0] nib;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    case (h)
      4'h0: hex_decode = 7'h01;  4'h1: hex_decode = 7'h4F;
      4'h2: hex_decode = 7'h12;  4'h3: hex_decode = 7'h06;
      4'h4: hex_decode = 7'h4C;  4'h5: hex_decode = 7'h24;
      4'h6: hex_decode = 7'h20;  4'h7: hex_decode = 7'h0F;
      4'h8: hex_decode = 7'h00;  4'h9: hex_decode = 7'h04;
      4'hA: hex_decode = 7'h08;  4'hB: hex_decode = 7'h60;
      4'hC: hex_decode = 7'h31;  4'hD: hex_decode = 7'h42;
      4'hE: hex_decode = 7'h30;  default: hex_decode = 7'h38;
    endcase
  endfunction

  always_comb begin
    slot_end = (pc_q == PW'(PRESCALE - 1));
    wrap     = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
    pc_d     = slot_end ? '0 : pc_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) idx_d = wrap ? '0 : idx_q + 1'b1;

    pend_val_d = load ? value : pend_val_q;
    pend_dp_d  = load ? dp_in : pend_dp_q;
    // A load on the wrap edge bypasses pending so it lands in the frame starting now.
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    if (wrap) begin
      disp_val_d = load ? value : pend_val_q;
      disp_dp_d  = load ? dp_in : pend_dp_q;
    end

    nib      = disp_val_q[{idx_q, 2'b00} +: 4];
    upper_nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (i >= int'(idx_q) && disp_val_q[4*i +: 4] != 4'h0) upper_nz = 1'b1;
    blanked = blank_lz && (idx_q != '0) && !upper_nz;

    seg_d        = blanked ? 7'h7F : hex_decode(nib);
    dp_d         = ~disp_dp_q[idx_q];
    an_d         = (pc_q == '0) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    frame_done_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
endmodule
